pipelined_addsub: RTL

- Parametrised, pipelined add/subtract unit for wide datapaths such as odometry accumulation and encoder deltas.
- Operand width is split into CHUNK-bit slices, one slice per pipeline stage. The carry is registered between stages, so there is no full-width ripple path.
- Supports add and subtract, signed overflow detection, and valid/ready backpressure.
- Generalises the fixed 20-bit combinational ripple adder to any WIDTH at a fixed clock rate.

---
 rtl/addsub_pkg.sv | 7 +
 rtl/addsub_chunk_stage.sv | 36 +++
 rtl/pipelined_addsub.sv | 90 +++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and stage-count helper for the pipelined add/subtract unit
package addsub_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} addsub_op_t;
  function automatic int num_stages(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction
endpackage

// File: rtl/addsub_chunk_stage.sv
// addsub_chunk_stage: registered W-bit slice adder with carry chain and valid pass-through
module addsub_chunk_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         v_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         v_out,
  output logic [W-1:0] s,
  output logic         c_out
);
  logic         v_q, v_d, c_q, c_d;
  logic [W-1:0] s_q, s_d;
  // Data only loads on real beats so bubbles leave the last result in place
  always_comb begin
    v_d = en ? v_in : v_q;
    {c_d, s_d} = (en && v_in) ? {1'b0, a} + {1'b0, b} + (W + 1)'(c_in) : {c_q, s_q};
    v_out = v_q;
    s = s_q;
    c_out = c_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v_q <= 1'b0;
      c_q <= 1'b0;
      s_q <= '0;
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      s_q <= s_d;
    end
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into CHUNK-bit stages with registered carries
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int CHUNK = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int STAGES = num_stages(WIDTH, CHUNK);
  logic              adv;
  logic [STAGES-1:0] v, co, vi, ci;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  lo_w  [STAGES];
  logic [WIDTH-1:0]  s_w   [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  r_q   [STAGES];
  logic [WIDTH-1:0]  r_d   [STAGES];
  // a_q/b_q skew operands toward their stage; r_q deskews finished low chunks
  always_comb begin
    adv = !v[STAGES-1] || out_ready;
    vi[0] = in_valid;
    ci[0] = (addsub_op_t'(op_sub) == OP_SUB) ? !c_in : c_in;
    src_a[0] = a;
    src_b[0] = (addsub_op_t'(op_sub) == OP_SUB) ? ~b : b;
    lo_w[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      vi[k] = v[k-1];
      ci[k] = co[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      lo_w[k] = r_q[k-1] | s_w[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = (adv && vi[k]) ? src_a[k] : a_q[k];
      b_d[k] = (adv && vi[k]) ? src_b[k] : b_q[k];
      r_d[k] = (adv && vi[k]) ? lo_w[k] : r_q[k];
    end
    in_ready = adv;
    out_valid = v[STAGES-1];
    sum = r_q[STAGES-1] | s_w[STAGES-1];
    c_out = co[STAGES-1];
    ovf = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) && (sum[WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      r_q <= '{default: '0};
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
    end
  // The final slice takes whatever bits remain when WIDTH is not a multiple of CHUNK
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int LO = i * CHUNK;
    localparam int W = (i == STAGES - 1) ? WIDTH - LO : CHUNK;
    logic [W-1:0] s;
    addsub_chunk_stage #(.W(W)) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (adv),
      .v_in  (vi[i]),
      .a     (src_a[i][LO +: W]),
      .b     (src_b[i][LO +: W]),
      .c_in  (ci[i]),
      .v_out (v[i]),
      .s     (s),
      .c_out (co[i])
    );
    assign s_w[i] = WIDTH'(s) << LO;
  end
endmodule
